// File: rtl/adder_rr_arbiter.sv
// adder_rr_arbiter
// Round-robin front end for one shared 4-operand, 4-bit adder. Up to NREQ
// requesters (2..8) each offer four packed nibbles with a valid/ready
// handshake. The winner's operands are steered onto the adder. The adder
// result is captured together with the winner's ID into a single output
// register, which drains through a valid/ready response port.
// IDW must equal clog2(NREQ).
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | output register empty; a grant may issue on any cycle
// HOLD  | output register full (rsp_valid=1); a grant may issue only
//       | in the cycle the consumer takes the current result
module adder_rr_arbiter #(
   parameter int NREQ = 4,
   parameter int IDW  = 2,
   parameter int CNTW = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NREQ-1:0]      req_valid,
   input  logic [16*NREQ-1:0]   req_ops,
   output logic [NREQ-1:0]      req_ready,
   output logic [3:0]           add_a,
   output logic [3:0]           add_b,
   output logic [3:0]           add_c,
   output logic [3:0]           add_d,
   input  logic [3:0]           add_sum,
   input  logic                 add_ov,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [IDW-1:0]       rsp_id,
   output logic [3:0]           rsp_sum,
   output logic                 rsp_ov,
   output logic [CNTW-1:0]      ov_count
);

   typedef enum logic {
      IDLE = 1'b0,
      HOLD = 1'b1
   } state_t;

   state_t           state;
   state_t           state_next;
   logic [IDW-1:0]   rr_ptr;
   logic [IDW-1:0]   rr_next;

   logic             can_issue;
   logic             grant_any;
   logic [IDW-1:0]   grant_idx;
   logic [NREQ-1:0]  grant;
   logic [15:0]      ops_sel;
   logic             load;
   logic [IDW-1:0]   scan_idx [NREQ];

   // (base + off) mod NREQ; both operands are below NREQ, so one
   // conditional subtract is enough and NREQ need not be a power of two.
   function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] base,
                                               input int off);
      int s;
      s = int'(base) + off;
      if (s >= NREQ) begin
         s = s - NREQ;
      end
      return s[IDW-1:0];
   endfunction

   // Grants are allowed out of reset when the output register is empty or
   // is being emptied this cycle.
   assign can_issue = rst && ((state == IDLE) || rsp_ready);

   // Scan order starting at the round-robin pointer.
   always_comb begin
      for (int k = 0; k < NREQ; k++) begin
         scan_idx[k] = wrap_add(rr_ptr, k);
      end
   end

   // Pick the first valid requester in scan order and make a one-hot grant.
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      grant_any = 1'b0;
      if (can_issue) begin
         for (int k = 0; k < NREQ; k++) begin
            if (!grant_any && req_valid[scan_idx[k]]) begin
               grant_any = 1'b1;
               grant_idx = scan_idx[k];
            end
         end
      end
      if (grant_any) begin
         grant[grant_idx] = 1'b1;
      end
   end

   assign req_ready = grant;

   // Steer the winner's operands to the adder; zero when nobody is granted
   // so the adder never sees a stale requester's data.
   always_comb begin
      ops_sel = '0;
      if (grant_any) begin
         ops_sel = req_ops[16*int'(grant_idx) +: 16];
      end
   end

   assign {add_a, add_b, add_c, add_d} = ops_sel;

   // Next state: a grant always loads the output register (this also covers
   // the accept-and-reload case in HOLD); otherwise an accept drains to IDLE.
   always_comb begin
      state_next = state;
      rr_next    = rr_ptr;
      load       = 1'b0;
      case (state)
         IDLE: begin
            if (grant_any) begin
               load       = 1'b1;
               state_next = HOLD;
            end
         end
         HOLD: begin
            if (grant_any) begin
               load = 1'b1;
            end else if (rsp_ready) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
      if (load) begin
         rr_next = wrap_add(grant_idx, 1);
      end
   end

   // State register and round-robin pointer.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state  <= IDLE;
         rr_ptr <= '0;
      end else begin
         state  <= state_next;
         rr_ptr <= rr_next;
      end
   end

   assign rsp_valid = (state == HOLD);

   // Output register: capture adder result and owner ID on a grant; hold
   // otherwise, so a stalled response stays stable.
   always_ff @(posedge clk) begin
      if (!rst) begin
         rsp_id  <= '0;
         rsp_sum <= '0;
         rsp_ov  <= 1'b0;
      end else if (load) begin
         rsp_id  <= grant_idx;
         rsp_sum <= add_sum;
         rsp_ov  <= add_ov;
      end
   end

   // Saturating count of accepted operations that overflowed.
   always_ff @(posedge clk) begin
      if (!rst) begin
         ov_count <= '0;
      end else if (load && add_ov && (ov_count != '1)) begin
         ov_count <= ov_count + CNTW'(1);
      end
   end

endmodule

// File: tb/tb_adder_rr_arbiter.sv
// Bench for adder_rr_arbiter: behavioural adder plus a round-robin reference
// model that predicts grants and pushes expected responses to a scoreboard;
// an independent monitor pops and compares whenever a response is presented.
module tb_adder_rr_arbiter;

   localparam int NREQ = 4;
   localparam int IDW  = 2;
   localparam int CNTW = 2;
   localparam int OV_MAX = (1 << CNTW) - 1;

   logic                clk;
   logic                rst;
   logic [NREQ-1:0]     req_valid;
   logic [16*NREQ-1:0]  req_ops;
   logic [NREQ-1:0]     req_ready;
   logic [3:0]          add_a, add_b, add_c, add_d;
   logic [3:0]          add_sum;
   logic                add_ov;
   logic                rsp_valid;
   logic                rsp_ready;
   logic [IDW-1:0]      rsp_id;
   logic [3:0]          rsp_sum;
   logic                rsp_ov;
   logic [CNTW-1:0]     ov_count;

   adder_rr_arbiter #(.NREQ(NREQ), .IDW(IDW), .CNTW(CNTW)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ops   (req_ops),
      .req_ready (req_ready),
      .add_a     (add_a),
      .add_b     (add_b),
      .add_c     (add_c),
      .add_d     (add_d),
      .add_sum   (add_sum),
      .add_ov    (add_ov),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_id    (rsp_id),
      .rsp_sum   (rsp_sum),
      .rsp_ov    (rsp_ov),
      .ov_count  (ov_count)
   );

   // Shared adder.
   logic [5:0] add_full;
   assign add_full = 6'(add_a) + 6'(add_b) + 6'(add_c) + 6'(add_d);
   assign add_sum  = add_full[3:0];
   assign add_ov   = (add_full > 6'd15);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int id;
      int sum;
      int ov;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   int   m_ptr  = 0;
   int   m_pend = 0;
   int   m_ov   = 0;

   task automatic check(input string name, input longint got, input longint exp);
      n_checks++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
      end
   endtask

   // Reference model: predict this cycle's grant from the round-robin rule,
   // compare combinational outputs, then advance to the upcoming edge.
   always @(negedge clk) begin : model
      int g;
      int j;
      int s;
      bit can;
      logic [NREQ-1:0] exp_rdy;
      logic [15:0] sel;
      exp_t e;
      can = rst && ((m_pend == 0) || rsp_ready);
      g = -1;
      if (can) begin
         for (int k = 0; k < NREQ; k++) begin
            j = (m_ptr + k) % NREQ;
            if (g < 0 && req_valid[j]) g = j;
         end
      end
      exp_rdy = '0;
      sel = '0;
      if (g >= 0) begin
         exp_rdy[g] = 1'b1;
         sel = req_ops[16*g +: 16];
      end
      check("req_ready", req_ready, exp_rdy);
      check("add_ops", {add_a, add_b, add_c, add_d}, sel);
      check("rsp_valid", rsp_valid, m_pend);
      check("ov_count", ov_count, m_ov);
      if (!rst) begin
         m_pend = 0;
         m_ptr  = 0;
         m_ov   = 0;
         sb.delete();
      end else if (g >= 0) begin
         s = int'(sel[15:12]) + int'(sel[11:8]) + int'(sel[7:4]) + int'(sel[3:0]);
         e.id  = g;
         e.sum = s % 16;
         e.ov  = (s > 15) ? 1 : 0;
         sb.push_back(e);
         m_pend = 1;
         m_ptr  = (g + 1) % NREQ;
         if (s > 15 && m_ov < OV_MAX) m_ov++;
      end else if (rsp_ready) begin
         m_pend = 0;
      end
   end

   // Monitor: every presented response must match the oldest expectation;
   // it is retired when the consumer accepts it.
   always @(negedge clk) begin : monitor
      if (rst && rsp_valid) begin
         if (sb.size() == 0) begin
            check("rsp_unexpected", 1, 0);
         end else begin
            check("rsp_id", rsp_id, sb[0].id);
            check("rsp_sum", rsp_sum, sb[0].sum);
            check("rsp_ov", rsp_ov, sb[0].ov);
            if (rsp_ready) void'(sb.pop_front());
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin : driver
      logic [NREQ-1:0] gnt_seen;
      logic [NREQ-1:0] exp_bp;
      logic [IDW-1:0]  hid;
      logic [3:0]      hsum;
      logic            hov;
      int              n;
      int              lastg;
      bit              done;

      // Reset held with every requester asking.
      rst       = 1'b0;
      rsp_ready = 1'b1;
      req_valid = '1;
      for (int i = 0; i < NREQ; i++) req_ops[16*i +: 16] = 16'($urandom);
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      check("first_grant", req_ready, 1);
      gnt_seen = req_valid & req_ready;

      // Round robin, all requesters continuously valid.
      for (int c = 0; c < 16; c++) begin
         @(posedge clk); #1;
         for (int i = 0; i < NREQ; i++)
            if (gnt_seen[i]) req_ops[16*i +: 16] = 16'($urandom);
         @(negedge clk);
         gnt_seen = req_valid & req_ready;
         check("rr_one_grant", $countones(gnt_seen), 1);
      end

      // Single result from requester 2.
      @(posedge clk); #1 req_valid = '0;
      @(negedge clk);
      @(posedge clk); #1;
      req_valid = 4'b0100;
      req_ops[47:32] = 16'h3451;
      done = 0;
      for (int c = 0; c < 10 && !done; c++) begin
         @(negedge clk);
         if (req_ready[2]) done = 1;
         @(posedge clk); #1;
      end
      check("single_granted", done, 1);
      req_valid = '0;
      @(negedge clk);
      check("single_valid", rsp_valid, 1);
      check("single_id", rsp_id, 2);
      check("single_sum", rsp_sum, 13);
      check("single_ov", rsp_ov, 0);

      // Overflow and counter saturation from a fresh reset.
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      @(posedge clk); #1;
      rst = 1'b1;
      req_valid = 4'b0010;
      req_ops[31:16] = 16'hFFFF;
      n = 0;
      for (int c = 0; c < 20 && n < 5; c++) begin
         @(negedge clk);
         if (req_ready[1]) n++;
         @(posedge clk); #1;
         if (n == 5) req_valid = '0;
      end
      req_valid = '0;
      check("ovf_grants", n, 5);
      @(negedge clk);
      check("ovf_count_sat", ov_count, 3);
      check("ovf_sum", rsp_sum, 12);
      check("ovf_flag", rsp_ov, 1);

      // Backpressure with requesters 0 and 1 pending.
      @(posedge clk); #1;
      req_valid = 4'b0011;
      req_ops[15:0]  = 16'($urandom);
      req_ops[31:16] = 16'($urandom);
      rsp_ready = 1'b1;
      @(negedge clk);
      gnt_seen = req_valid & req_ready;
      lastg = gnt_seen[1] ? 1 : 0;
      check("bp_first_grant", $countones(gnt_seen), 1);
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      req_ops[16*lastg +: 16] = 16'($urandom);
      @(negedge clk);
      hid = rsp_id; hsum = rsp_sum; hov = rsp_ov;
      check("bp_hold_valid", rsp_valid, 1);
      for (int c = 0; c < 4; c++) begin
         check("bp_ready_low", req_ready, 0);
         check("bp_id_stable", rsp_id, hid);
         check("bp_sum_stable", rsp_sum, hsum);
         check("bp_ov_stable", rsp_ov, hov);
         if (c < 3) begin
            @(posedge clk); #1;
            @(negedge clk);
         end
      end
      @(posedge clk); #1 rsp_ready = 1'b1;
      @(negedge clk);
      exp_bp = (lastg == 0) ? 4'b0010 : 4'b0001;
      check("bp_next_grant", req_ready, exp_bp);
      @(posedge clk); #1 req_valid = '0;
      @(negedge clk);
      check("bp_reload_valid", rsp_valid, 1);
      check("bp_reload_id", rsp_id, 1 - lastg);

      // Random traffic with withdrawals and random backpressure.
      for (int c = 0; c < 400; c++) begin
         gnt_seen = req_valid & req_ready;
         @(posedge clk); #1;
         for (int i = 0; i < NREQ; i++) begin
            if (gnt_seen[i] || !req_valid[i]) begin
               req_valid[i] = ($urandom_range(0, 2) != 0);
               req_ops[16*i +: 16] = 16'($urandom);
            end else if ($urandom_range(0, 15) == 0) begin
               req_valid[i] = 1'b0;
            end
         end
         rsp_ready = ($urandom_range(0, 3) != 0);
         @(negedge clk);
      end

      // Reset while a result is stalled.
      @(posedge clk); #1;
      req_valid = '0;
      rsp_ready = 1'b1;
      @(negedge clk);
      @(posedge clk); #1;
      req_valid = 4'b0001;
      req_ops[15:0] = 16'($urandom);
      @(negedge clk);
      @(posedge clk); #1;
      req_valid = '0;
      rsp_ready = 1'b0;
      @(negedge clk);
      check("mid_rst_pending", rsp_valid, 1);
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      @(posedge clk); #1;
      rst = 1'b1;
      rsp_ready = 1'b1;
      @(negedge clk);
      check("mid_rst_dropped", rsp_valid, 0);
      @(posedge clk); #1 req_valid = '1;
      @(negedge clk);
      check("ptr_after_reset", req_ready, 1);

      // Drain and confirm every expected response was presented.
      @(posedge clk); #1 req_valid = '0;
      repeat (3) @(posedge clk);
      #1;
      check("sb_empty", sb.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/adder_rr_arbiter.md
Name: adder_rr_arbiter

Overview:
- Shares one 4-operand, 4-bit `adder` instance (ports `a`, `b`, `c`, `d`, `sum`, `ov`; `ov` = 1 when the true sum exceeds 15) among NREQ requesters.
- Arbitration is round-robin. Each requester offers four packed operands with a valid/ready handshake.
- The block drives the adder, registers its result and returns it with the requester ID through a single response port with backpressure.
- It also keeps a saturating count of overflowed results for debug.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, 2, requester-ID width; must equal clog2(NREQ).
- CNTW, 8, width of the overflow event counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
- req_valid  input  NREQ  bit i = requester i has an operation pending.
- req_ops  input  16*NREQ  requester i operands at [16i+15:16i] = {a[3:0], b[3:0], c[3:0], d[3:0]}.
- req_ready  output  NREQ  one-hot grant; combinational.
- add_a, add_b, add_c, add_d  output  4 each  operands to the shared adder; combinational.
- add_sum  input  4  adder sum, combinational from add_a..add_d.
- add_ov  input  1  adder overflow, combinational.
- rsp_valid  output  1  registered result available.
- rsp_ready  input  1  consumer accepts the result.
- rsp_id  output  IDW  index of the requester that owns the result.
- rsp_sum  output  4  registered sum.
- rsp_ov  output  1  registered overflow.
- ov_count  output  CNTW  number of accepted operations with ov=1; saturates at all-ones.

Behaviour:
- Reset, when rst=0 at a clk edge:
  - state=IDLE, rr_ptr=0.
  - rsp_valid=0, rsp_id=0, rsp_sum=0, rsp_ov=0, ov_count=0.
  - While rst=0, req_ready=0 and add_a..add_d=0.
  - Reset overrides everything, including a result pending mid-handshake; that result is dropped.
- States: IDLE (output register empty) and HOLD (rsp_valid=1).
- Grant window: `can_issue = (state==IDLE) || (state==HOLD && rsp_ready)`.
- Arbitration (combinational):
  - If can_issue, scan indices rr_ptr, rr_ptr+1, ... mod NREQ.
  - The first i with req_valid[i]=1 gets req_ready[i]=1; every other bit is 0.
  - No valid requester, or can_issue=0: req_ready=0.
- Operand mux:
  - add_a..add_d = fields of the granted requester's req_ops.
  - With no grant they are all 0, so the adder never sees stale or undriven values.
- Transfer: a requester transfers at the edge where req_valid[i] && req_ready[i]. At that edge:
  - rsp_sum<=add_sum, rsp_ov<=add_ov, rsp_id<=i, rsp_valid<=1, state<=HOLD.
  - rr_ptr<=(i+1) mod NREQ.
  - if add_ov, ov_count<=ov_count+1 unless it is already all-ones.
- Latency: result visible 1 cycle after the grant edge.
- Throughput: one operation per cycle when rsp_ready is held at 1 (back-to-back).
- HOLD with rsp_ready=0:
  - rsp_id, rsp_sum and rsp_ov are held stable.
  - req_ready=0; no new grant is issued.
- HOLD with rsp_ready=1 and no grant: rsp_valid<=0, state<=IDLE, rr_ptr unchanged.
- Simultaneous response accept and new grant: the output register is reloaded in the same edge and rsp_valid stays 1. This case has priority over the drain to IDLE.
- rr_ptr wraps from NREQ-1 to 0.
- Fairness: a requester that keeps req_valid asserted is granted within NREQ grants.
- Requester contract:
  - A requester must hold req_valid and its req_ops stable until granted.
  - Deasserting req_valid before the grant withdraws the request; this is legal.
- Width rule: add_sum/add_ov are passed through unmodified. The arbiter adds no carry logic, and sum is the low 4 bits of a+b+c+d.

Test Plan:
- Reset: hold rst=0 for 3 cycles with all req_valid=1. Required: req_ready=0, rsp_valid=0, ov_count=0 throughout. On release, the first grant goes to requester 0.
- Round-robin: all four requesters valid continuously, rsp_ready=1. Required grant order 0,1,2,3,0,… with one grant per cycle and rsp_id following one cycle later.
- Single result: requester 2 only, ops a=3 b=4 c=5 d=1. Required: next cycle rsp_valid=1, rsp_id=2, rsp_sum=13, rsp_ov=0.
- Overflow and saturation:
  - a=b=c=d=15 gives rsp_sum=12, rsp_ov=1, and ov_count increments.
  - With CNTW=2, five such operations leave ov_count=3.
- Backpressure: hold rsp_ready=0 for 4 cycles while requesters 0 and 1 are valid. Required: rsp fields stable, req_ready=0 throughout. When rsp_ready rises, the grant goes to the next requester after the last one granted, and the output reloads in the same edge.
- Reset mid-operation: rsp_valid=1 with rsp_ready=0, then assert rst=0 for one cycle. Required: rsp_valid=0, rr_ptr=0, and the pending result is not re-presented.
